uart_axi_bridge: RTL



---
 rtl/uart_axi_bridge_if.sv | 51 +++++
 rtl/uart_axi_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_axi_bridge_if.sv
// uart_axi_bridge_if: AXI4 channel bundle between the core's UART memory port and the bridge.
//   ar_*/aw_*/w_* : request channels, driven by the master
//   r_*/b_*       : response channels, driven by the slave
//   *_ready       : driven by the receiving side of each channel
interface uart_axi_bridge_if;
    logic [7:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        ar_valid;
    logic        ar_ready;
    logic [7:0]  r_id;
    logic [1:0]  r_resp;
    logic [31:0] r_data;
    logic        r_last;
    logic        r_valid;
    logic        r_ready;
    logic [7:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;
    logic [7:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;

    modport master (
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output w_data, w_strb, w_last, w_valid, b_ready,
        input  ar_ready, r_id, r_resp, r_data, r_last, r_valid,
        input  aw_ready, w_ready, b_id, b_resp, b_valid
    );

    modport slave (
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  w_data, w_strb, w_last, w_valid, b_ready,
        output ar_ready, r_id, r_resp, r_data, r_last, r_valid,
        output aw_ready, w_ready, b_id, b_resp, b_valid
    );
endinterface

// File: rtl/uart_axi_bridge.sv
// uart_axi_bridge: AXI4 slave exposing a UART DATA (0x0) / STATUS (0x4) register pair over TX/RX byte buffers.
//   clk, rst  : clock; synchronous active-low reset
//   io_uart   : AXI4 slave port (uart_axi_bridge_if.slave)
//   tx_data   : byte to the PHY transmitter, valid with tx_start
//   tx_start  : one-cycle launch pulse
//   tx_busy   : transmitter busy
//   rx_data   : received byte, valid with rx_valid
//   rx_valid  : one-cycle received-byte strobe
// Build option UART_RX_FIFO_EN: RX buffer is an RX_DEPTH-entry FIFO; otherwise a single holding byte.
module uart_axi_bridge #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    uart_axi_bridge_if.slave  io_uart,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid
);
    if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_tx
        $error("TX_DEPTH must be a power of 2 and at least 2");
    end
    if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rx
        $error("RX_DEPTH must be a power of 2 and at least 2");
    end

    localparam int TAW = $clog2(TX_DEPTH);

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    r_state_t rs, rs_nx;
    w_state_t ws, ws_nx;

    logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [7:0] r_cnt;
    logic       w_sel, w_bad;
    logic       overrun, ov_set, ov_clr;
    logic       rx_push, rx_pop, rx_full, rx_nonempty;
    logic [7:0] rx_head;
    logic       tx_push, tx_pop, tx_full, tx_empty, tx_lock;
    logic [7:0] tx_mem [TX_DEPTH];
    logic [TAW:0] tx_wp, tx_rp;

    logic unused_ok;
    assign unused_ok = ^{io_uart.ar_addr[31:3], io_uart.ar_addr[1:0], io_uart.ar_size, io_uart.ar_burst,
                         io_uart.aw_addr[31:3], io_uart.aw_addr[1:0], io_uart.aw_size, io_uart.aw_burst,
                         io_uart.w_data[31:8], io_uart.w_strb[3:1]};

    assign ar_hs = io_uart.ar_valid && io_uart.ar_ready;
    assign r_hs  = io_uart.r_valid && io_uart.r_ready;
    assign aw_hs = io_uart.aw_valid && io_uart.aw_ready;
    assign w_hs  = io_uart.w_valid && io_uart.w_ready;
    assign b_hs  = io_uart.b_valid && io_uart.b_ready;

    // Read FSM
    always_ff @(posedge clk) begin
        if (!rst) rs <= R_IDLE;
        else      rs <= rs_nx;
    end

    always_comb begin
        io_uart.ar_ready = rst && rs == R_IDLE;
        io_uart.r_valid  = rs == R_DATA;
        io_uart.r_last   = rs == R_DATA && r_cnt == 8'd0;
        rs_nx = (io_uart.ar_valid && io_uart.ar_ready) ? R_DATA :
                (io_uart.r_valid && io_uart.r_ready && io_uart.r_last) ? R_IDLE : rs;
    end

    // Side effects happen at the AR handshake so the beat data is final before r_valid rises.
    assign rx_pop = ar_hs && io_uart.ar_len == 8'd0 && !io_uart.ar_addr[2] && rx_nonempty;
    assign ov_clr = ar_hs && io_uart.ar_len == 8'd0 && io_uart.ar_addr[2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            io_uart.r_id   <= '0;
            io_uart.r_resp <= '0;
            io_uart.r_data <= '0;
            r_cnt          <= '0;
        end else if (ar_hs) begin
            io_uart.r_id   <= io_uart.ar_id;
            io_uart.r_resp <= io_uart.ar_len != 8'd0 ? 2'b10 : 2'b00;
            io_uart.r_data <= io_uart.ar_len != 8'd0 ? 32'd0 :
                              io_uart.ar_addr[2] ? {29'd0, overrun, rx_nonempty, !tx_full} :
                              rx_nonempty ? {24'd0, rx_head} : 32'd0;
            r_cnt          <= io_uart.ar_len;
        end else if (r_hs && r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    // Write FSM
    always_ff @(posedge clk) begin
        if (!rst) ws <= W_IDLE;
        else      ws <= ws_nx;
    end

    always_comb begin
        io_uart.aw_ready = rst && ws == W_IDLE;
        io_uart.w_ready  = ws == W_DATA && !(!w_sel && tx_full);
        io_uart.b_valid  = ws == W_RESP;
        ws_nx = (io_uart.aw_valid && io_uart.aw_ready) ? W_DATA :
                (io_uart.w_valid && io_uart.w_ready && (!w_bad || io_uart.w_last)) ? W_RESP :
                (io_uart.b_valid && io_uart.b_ready) ? W_IDLE : ws;
    end

    assign tx_push = w_hs && !w_sel && !w_bad && io_uart.w_strb[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            io_uart.b_id   <= '0;
            io_uart.b_resp <= '0;
            w_sel          <= 1'b0;
            w_bad          <= 1'b0;
        end else if (aw_hs) begin
            io_uart.b_id   <= io_uart.aw_id;
            io_uart.b_resp <= io_uart.aw_len != 8'd0 ? 2'b10 : 2'b00;
            w_sel          <= io_uart.aw_addr[2];
            w_bad          <= io_uart.aw_len != 8'd0;
        end
    end

    // TX FIFO and drain; the lockout covers the cycle before the PHY can raise tx_busy.
    assign tx_empty = tx_wp == tx_rp;
    assign tx_full  = tx_wp[TAW] != tx_rp[TAW] && tx_wp[TAW-1:0] == tx_rp[TAW-1:0];
    assign tx_pop   = !tx_empty && !tx_busy && !tx_lock;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= io_uart.w_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            tx_lock  <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop) begin
                tx_data <= tx_mem[tx_rp[TAW-1:0]];
                tx_rp   <= tx_rp + 1'b1;
            end
            tx_start <= tx_pop;
            tx_lock  <= tx_pop;
        end
    end

    // RX buffer; a simultaneous pop frees the slot, so a push into a full buffer still lands.
    assign rx_push = rx_valid && (!rx_full || rx_pop);
    assign ov_set  = rx_valid && !rx_push;

`ifdef UART_RX_FIFO_EN
    localparam int RAW = $clog2(RX_DEPTH);
    logic [7:0] rx_mem [RX_DEPTH];
    logic [RAW:0] rx_wp, rx_rp;

    assign rx_nonempty = rx_wp != rx_rp;
    assign rx_full     = rx_wp[RAW] != rx_rp[RAW] && rx_wp[RAW-1:0] == rx_rp[RAW-1:0];
    assign rx_head     = rx_mem[rx_rp[RAW-1:0]];

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        end
    end
`else
    logic [7:0] rx_hold;
    logic       rx_hv;

    assign rx_nonempty = rx_hv;
    assign rx_full     = rx_hv;
    assign rx_head     = rx_hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_hold <= '0;
            rx_hv   <= 1'b0;
        end else begin
            if (rx_push) rx_hold <= rx_data;
            rx_hv <= rx_push || (rx_hv && !rx_pop);
        end
    end
`endif

    // A new overrun in the same cycle as a STATUS read stays visible for the next read.
    always_ff @(posedge clk) begin
        if (!rst) overrun <= 1'b0;
        else      overrun <= ov_set || (overrun && !ov_clr);
    end
endmodule
